alu_cmd_sequencer: RTL
======================

Name: alu_cmd_sequencer

Overview:
- Command-side initiator for the datapath ALU.
- Accepts one register-to-register or register-immediate command per handshake and reads operands from an internal 8x32 register file.
- Drives the ALU operand/opcode inputs, captures the returned result and N/Z/C/V flags, and writes back conditionally.
- Sits between the instruction/control logic and the combinational ALU; it owns the architectural register file and flag register.

Parameters:
- NREGS, 8, number of 32-bit registers (power of two); r0 reads 0 and ignores writes.
- AW, 3, register address width, log2(NREGS).

Ports:
- clk, in, 1, rising-edge clock.
- reset_n, in, 1, asynchronous active-low reset.
- cmd_valid, in, 1, command present.
- cmd_ready, out, 1, sequencer can accept a command.
- cmd_op, in, 4, ALU opcode, forwarded unchanged.
- cmd_rd / cmd_rs1 / cmd_rs2, in, AW each, destination and source registers.
- cmd_imm_en, in, 1, use the immediate in place of rs2.
- cmd_imm, in, 16, immediate, sign-extended to 32 bits.
- cmd_cond, in, 3, execution condition.
- cmd_setf, in, 1, update flags on an executed command.
- alu_a, alu_b, out, 32, registered ALU operands.
- alu_op, out, 4, registered ALU opcode.
- alu_result, in, 32, ALU result (combinational return).
- alu_n, alu_z, alu_c, alu_v, in, 1 each, ALU flags.
- rsp_valid, out, 1, one-cycle completion pulse.
- rsp_data, out, 32, captured result, valid with rsp_valid.
- rsp_exec, out, 1, condition passed (write/flag update performed).
- flags, out, 4, architectural {N,Z,C,V}.
- dbg_addr, in, AW, debug read address.
- dbg_data, out, 32, combinational register read; r0 reads 0.

Behaviour:
- Reset (async, reset_n=0): state IDLE; all registers, flags, alu_a/alu_b/alu_op, rsp_* cleared to 0. cmd_ready=0 while reset_n is low and 1 in IDLE after release. An in-flight command is dropped with no write.
- FSM: IDLE -> EXEC -> WB -> IDLE. Fixed 3 cycles per command, no pipelining.
- cmd_ready=1 only in IDLE. Commands are accepted when cmd_valid&cmd_ready at a rising edge.
- Accept edge k:
  - latch rd, cond, setf;
  - alu_a <= R[rs1];
  - alu_b <= cmd_imm_en ? sext(cmd_imm) : R[rs2];
  - alu_op <= cmd_op;
  - state -> EXEC.
- Edge k+1: res_q <= alu_result; flag_q <= {alu_n,alu_z,alu_c,alu_v}; state -> WB. alu_a/b/op hold stable through EXEC and WB.
- During WB (between edges k+1 and k+2):
  - rsp_valid=1, rsp_data=res_q, rsp_exec=condition result.
  - Condition is evaluated from the architectural flags register.
- Edge k+2:
  - if pass and rd!=0: R[rd] <= res_q;
  - if pass and setf: flags <= flag_q;
  - state -> IDLE.
- Condition encodings: 0 AL, 1 EQ(Z), 2 NE(!Z), 3 MI(N), 4 PL(!N), 5 CS(C), 6 CC(!C), 7 VS(V).
- Failed condition: rsp_valid still pulses with rsp_data=res_q and rsp_exec=0. No register write, no flag change.
- Flags are taken verbatim from the ALU; there is no local recomputation.
- rsp_valid has no backpressure; it is high for exactly one cycle per accepted command.
- dbg_data during WB shows the pre-write value; the new value is visible the cycle after edge k+2.
- rd==rs1/rs2 is hazard-free because execution is serialized. Operands read at accept see all prior writes.
- cmd_* inputs outside an accept edge are ignored. cmd_valid may stay high; the next accept occurs at the first IDLE edge.
- Immediate: bit 15 replicated into bits 31:16 (0x8000 -> 0xFFFF_8000).

Test Plan:
- Reset then accept {op=4'h4, rs1=0, imm_en=1, imm=0x0005, rd=1, cond=AL, setf=1}; ALU model returns 0x5, NZCV=0000:
  - alu_a=0, alu_b=0x5 one cycle after accept;
  - rsp_valid pulses one cycle later with rsp_data=0x5, rsp_exec=1;
  - dbg_data(r1)=0x5 after WB; cmd_ready low for 2 cycles.
- imm=0xFFFF -> alu_b=0xFFFF_FFFF. Next command uses rs1=1, rs2=1, rd=2 -> alu_a=alu_b=R1 value, R2 written.
- Model returns 0x0 with Z=1 on a setf command -> flags=0100. Next cond=NE command: rsp_exec=0, rd unchanged, flags unchanged. Then cond=EQ: rsp_exec=1, rd written.
- Command with rd=0, result 0xDEAD_BEEF -> dbg_data(r0)=0. setf=0 with NZCV=1111 -> flags unchanged.
- Hold cmd_valid high for 3 back-to-back commands -> accepts exactly every 3rd cycle, three rsp_valid pulses, results in order.
- Assert reset_n low during EXEC -> no rsp_valid, no register write, all outputs 0. After release, cmd_ready=1 and the next command executes normally.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Command-side initiator for the datapath ALU. It accepts one command per
// handshake and reads the operands from its own register file. It drives the
// registered operands and opcode to a combinational ALU. One cycle later it
// captures the ALU result and N/Z/C/V flags. It then writes the result back
// if the command's condition passes against the architectural flags.
// Commands are fully serialized: IDLE -> EXEC -> WB -> IDLE, 3 cycles each.
//
// Ports
//   clk, reset_n           rising-edge clock, async active-low reset
//   cmd_valid / cmd_ready  command handshake (ready only in IDLE)
//   cmd_op                 ALU opcode, forwarded unchanged to alu_op
//   cmd_rd/rs1/rs2         destination and source register addresses
//   cmd_imm_en, cmd_imm    use sign-extended 16-bit immediate instead of rs2
//   cmd_cond               execution condition (AL/EQ/NE/MI/PL/CS/CC/VS)
//   cmd_setf               update flags when the command executes
//   alu_a, alu_b, alu_op   registered ALU inputs, stable through EXEC and WB
//   alu_result, alu_n/z/c/v combinational ALU return
//   rsp_valid              one-cycle completion pulse (during WB)
//   rsp_data               captured ALU result, valid with rsp_valid
//   rsp_exec               condition passed (write / flag update performed)
//   flags                  architectural {N,Z,C,V}
//   dbg_addr, dbg_data     combinational register read port, r0 reads 0
// ---------------------------------------------------------------------------
module alu_cmd_sequencer #(
  parameter int NREGS = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs1,
  input  logic [AW-1:0] cmd_rs2,
  input  logic          cmd_imm_en,
  input  logic [15:0]   cmd_imm,
  input  logic [2:0]    cmd_cond,
  input  logic          cmd_setf,
  output logic [31:0]   alu_a,
  output logic [31:0]   alu_b,
  output logic [3:0]    alu_op,
  input  logic [31:0]   alu_result,
  input  logic          alu_n,
  input  logic          alu_z,
  input  logic          alu_c,
  input  logic          alu_v,
  output logic          rsp_valid,
  output logic [31:0]   rsp_data,
  output logic          rsp_exec,
  output logic [3:0]    flags,
  input  logic [AW-1:0] dbg_addr,
  output logic [31:0]   dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    C_AL = 3'd0,
    C_EQ = 3'd1,
    C_NE = 3'd2,
    C_MI = 3'd3,
    C_PL = 3'd4,
    C_CS = 3'd5,
    C_CC = 3'd6,
    C_VS = 3'd7
  } cond_t;

  state_t          state;
  logic [31:0]     rf [NREGS];
  logic [AW-1:0]   rd_q;
  cond_t           cond_q;
  logic            setf_q;
  logic [3:0]      flag_q;   // flags captured from the ALU, pending write
  logic            cond_pass;
  logic [31:0]     rs1_val;
  logic [31:0]     rs2_val;
  logic [31:0]     imm_sext;

  // r0 is hardwired to zero on every read path. It is never written, so
  // rf[0] stays at its reset value. The read mux also masks it explicitly.
  assign rs1_val  = (cmd_rs1  == '0) ? 32'd0 : rf[cmd_rs1];
  assign rs2_val  = (cmd_rs2  == '0) ? 32'd0 : rf[cmd_rs2];
  assign dbg_data = (dbg_addr == '0) ? 32'd0 : rf[dbg_addr];
  assign imm_sext = {{16{cmd_imm[15]}}, cmd_imm};

  // cmd_ready is gated by reset_n. While reset is held, state already
  // reads IDLE, but no command may be offered ready.
  assign cmd_ready = reset_n && (state == S_IDLE);

  // The condition is evaluated against the architectural flags. Those flags
  // cannot change between EXEC and the WB write edge, so the value registered
  // into rsp_exec at the end of EXEC is the value that governs the write.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default before the
    // case, so no path can leave it unassigned and infer a latch.
    cond_pass = 1'b0;
    case (cond_q)
      C_AL: cond_pass = 1'b1;
      C_EQ: cond_pass = flags[2];
      C_NE: cond_pass = !flags[2];
      C_MI: cond_pass = flags[3];
      C_PL: cond_pass = !flags[3];
      C_CS: cond_pass = flags[1];
      C_CC: cond_pass = !flags[1];
      C_VS: cond_pass = flags[0];
      default: cond_pass = 1'b0;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments. Then every register
  // samples pre-edge values, whatever the statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      rd_q      <= '0;
      cond_q    <= C_AL;
      setf_q    <= 1'b0;
      flag_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_exec  <= 1'b0;
      rsp_data  <= '0;
      flags     <= '0;
      // NOTE: the register file is architectural state and must read zero
      // after reset. It is small enough to sit in flops with an async clear.
      // It is therefore reset here rather than left uninitialized as RAM.
      for (int i = 0; i < NREGS; i++) begin
        rf[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            rd_q   <= cmd_rd;
            cond_q <= cond_t'(cmd_cond);
            setf_q <= cmd_setf;
            alu_a  <= rs1_val;
            alu_b  <= cmd_imm_en ? imm_sext : rs2_val;
            alu_op <= cmd_op;
            state  <= S_EXEC;
          end
        end

        S_EXEC: begin
          rsp_data  <= alu_result;
          flag_q    <= {alu_n, alu_z, alu_c, alu_v};
          rsp_valid <= 1'b1;
          rsp_exec  <= cond_pass;
          state     <= S_WB;
        end

        S_WB: begin
          if (rsp_exec && (rd_q != '0)) begin
            rf[rd_q] <= rsp_data;
          end
          if (rsp_exec && setf_q) begin
            flags <= flag_q;
          end
          rsp_valid <= 1'b0;
          rsp_exec  <= 1'b0;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
